// File: rtl/rf_port_arb.sv
// rf_port_arb: init sequencer and two-port round-robin arbiter
// in front of a 16x32 register file with one read/write path.
module rf_port_arb #(
    parameter int              AW       = 4,
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic [AW-1:0] rf_ra,
    input  logic [DW-1:0] rf_da,
    output logic          rf_wen,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_din
);

    localparam int NREGS = 2 ** AW;
    localparam logic [AW:0] CNT_LAST = (AW + 1)'(NREGS - 1);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [AW:0] cnt, cnt_nx;
    // 1 = debug port held the most recent grant
    logic        last, last_nx;
    logic        g0, g1;
    logic        rd0, rd1;

    // Round-robin grant; combinational, suppressed by reset, INIT and clr
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset && state == S_RUN && !clr) begin
            if (req0 && req1) begin
                if (last) begin
                    g0 = 1'b1;
                end else begin
                    g1 = 1'b1;
                end
            end else if (req0) begin
                g0 = 1'b1;
            end else if (req1) begin
                g1 = 1'b1;
            end
        end
    end

    assign gnt0 = g0;
    assign gnt1 = g1;
    assign rd0  = g0 && !we0;
    assign rd1  = g1 && !we1;
    assign busy = !reset && state == S_INIT;

    // Next state, init counter and grant pointer
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        unique case (state)
            S_INIT: begin
                if (cnt == CNT_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (clr) begin
                    state_nx = S_INIT;
                    cnt_nx   = '0;
                end
                if (g0) begin
                    last_nx = 1'b0;
                end else if (g1) begin
                    last_nx = 1'b1;
                end
            end
            default: begin
                state_nx = S_INIT;
                cnt_nx   = '0;
            end
        endcase
    end

    // Register-file access path: init writes, or the granted port
    always_comb begin
        rf_wen = 1'b0;
        rf_wa  = '0;
        rf_din = '0;
        rf_ra  = '0;
        if (!reset) begin
            if (state == S_INIT) begin
                rf_wen = 1'b1;
                rf_wa  = cnt[AW-1:0];
                rf_din = INIT_VAL;
            end else if (g0) begin
                if (we0) begin
                    rf_wen = 1'b1;
                    rf_wa  = addr0;
                    rf_din = wdata0;
                end else begin
                    rf_ra = addr0;
                end
            end else if (g1) begin
                if (we1) begin
                    rf_wen = 1'b1;
                    rf_wa  = addr1;
                    rf_din = wdata1;
                end else begin
                    rf_ra = addr1;
                end
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
        end
    end

    // Registered read return for the core port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rdata0  <= '0;
        end else begin
            rvalid0 <= rd0;
            if (rd0) begin
                rdata0 <= rf_da;
            end
        end
    end

    // Registered read return for the debug port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid1 <= 1'b0;
            rdata1  <= '0;
        end else begin
            rvalid1 <= rd1;
            if (rd1) begin
                rdata1 <= rf_da;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_arb.sv
// tb_rf_port_arb: directed checks of init, arbitration, reads,
// clr and reset behaviour, with a behavioural 16x32 register file.
module tb_rf_port_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        busy;
    logic        req0, we0, gnt0, rvalid0;
    logic [3:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic        req1, we1, gnt1, rvalid1;
    logic [3:0]  addr1;
    logic [31:0] wdata1, rdata1;
    logic [3:0]  rf_ra, rf_wa;
    logic [31:0] rf_da, rf_din;
    logic        rf_wen;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];

    rf_port_arb dut (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .rf_ra(rf_ra), .rf_da(rf_da), .rf_wen(rf_wen),
        .rf_wa(rf_wa), .rf_din(rf_din)
    );

    always #5 clk = ~clk;

    // Behavioural register file: synchronous write, async read
    always @(posedge clk) begin
        if (rf_wen) mem[rf_wa] <= rf_din;
    end
    assign rf_da = mem[rf_ra];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 32'hFFFF_FFFF;
        step();
        step();
        #3;
        checks++;
        if ({busy, gnt0, gnt1, rvalid0, rvalid1, rf_wen} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=000000",
                     {busy, gnt0, gnt1, rvalid0, rvalid1, rf_wen});
        end
        checks++;
        if ({rf_wa, rf_ra, rf_din, rdata0, rdata1} !== 104'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0",
                     {rf_wa, rf_ra, rf_din, rdata0, rdata1});
        end
        req0 = 1'b0; we0 = 1'b0;
    endtask

    task automatic test_init();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #3;
            checks++;
            if ({busy, rf_wen, rf_wa, rf_din} !== {1'b1, 1'b1, 4'(i), 32'h0}) begin
                errors++;
                $display("FAIL init_%0d got busy=%b wen=%b wa=%0d din=%h exp 1 1 %0d 0",
                         i, busy, rf_wen, rf_wa, rf_din, i);
            end
            step();
        end
        #3;
        checks++;
        if ({busy, rf_wen} !== 2'b00) begin
            errors++;
            $display("FAIL init_done got busy=%b wen=%b exp 0 0", busy, rf_wen);
        end
    endtask

    task automatic test_write_read();
        step();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 32'hDEAD_BEEF;
        #3;
        checks++;
        if ({gnt0, gnt1, rf_wen, rf_wa, rf_din} !== {3'b101, 4'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL wr_grant got g0=%b g1=%b wen=%b wa=%0d din=%h",
                     gnt0, gnt1, rf_wen, rf_wa, rf_din);
        end
        step();
        we0 = 1'b0;
        #3;
        checks++;
        if ({gnt0, gnt1, rf_wen, rf_ra} !== {3'b100, 4'd5}) begin
            errors++;
            $display("FAIL rd_grant got g0=%b g1=%b wen=%b ra=%0d exp 1 0 0 5",
                     gnt0, gnt1, rf_wen, rf_ra);
        end
        step();
        req0 = 1'b0;
        #3;
        checks++;
        if ({rvalid0, rdata0} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_data got v=%b d=%h exp 1 deadbeef", rvalid0, rdata0);
        end
        checks++;
        if ({gnt0, gnt1, rf_wen, rf_wa, rf_ra, rf_din} !== 43'h0) begin
            errors++;
            $display("FAIL idle_rf got %h exp 0",
                     {gnt0, gnt1, rf_wen, rf_wa, rf_ra, rf_din});
        end
        step();
        #3;
        checks++;
        if ({rvalid0, rdata0} !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_hold got v=%b d=%h exp 0 deadbeef", rvalid0, rdata0);
        end
    endtask

    task automatic test_contention();
        step();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 32'h1234_5678;
        #3;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL wr_r3 got g0=%b exp 1", gnt0);
        end
        step();
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
        #3;
        checks++;
        if ({gnt0, gnt1, rf_ra} !== {2'b01, 4'd7}) begin
            errors++;
            $display("FAIL dbg_rd got g0=%b g1=%b ra=%0d exp 0 1 7", gnt0, gnt1, rf_ra);
        end
        step();
        req1 = 1'b0;
        #3;
        checks++;
        if ({rvalid1, rdata1} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL dbg_rd_data got v=%b d=%h exp 1 0", rvalid1, rdata1);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            req0 = 1'b1; we0 = 1'b1; addr0 = 4'd9; wdata0 = 32'(k);
            req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
            #3;
            checks++;
            if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_%0d got g0=%b g1=%b", k, gnt0, gnt1);
            end
            if (k > 0 && k % 2 == 0) begin
                checks++;
                if ({rvalid1, rdata1} !== {1'b1, 32'h1234_5678}) begin
                    errors++;
                    $display("FAIL rr_data_%0d got v=%b d=%h exp 1 12345678",
                             k, rvalid1, rdata1);
                end
            end
        end
        step();
        req0 = 1'b0; req1 = 1'b0;
        #3;
        checks++;
        if ({gnt0, gnt1, rvalid1, rdata1} !== {3'b001, 32'h1234_5678}) begin
            errors++;
            $display("FAIL rr_last got g0=%b g1=%b v=%b d=%h",
                     gnt0, gnt1, rvalid1, rdata1);
        end
    endtask

    task automatic test_clr();
        step();
        clr = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
        #3;
        checks++;
        if ({gnt0, rf_wen, busy} !== 3'b000) begin
            errors++;
            $display("FAIL clr_nogrant got g0=%b wen=%b busy=%b exp 000",
                     gnt0, rf_wen, busy);
        end
        step();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #3;
            checks++;
            if ({busy, gnt0, rf_wa} !== {2'b10, 4'(i)}) begin
                errors++;
                $display("FAIL clr_init_%0d got busy=%b g0=%b wa=%0d",
                         i, busy, gnt0, rf_wa);
            end
            step();
        end
        #3;
        checks++;
        if ({busy, gnt0, rf_ra} !== {2'b01, 4'd5}) begin
            errors++;
            $display("FAIL clr_run got busy=%b g0=%b ra=%0d exp 0 1 5",
                     busy, gnt0, rf_ra);
        end
        step();
        req0 = 1'b0;
        #3;
        checks++;
        if ({rvalid0, rdata0} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL clr_r5 got v=%b d=%h exp 1 0", rvalid0, rdata0);
        end
    endtask

    task automatic test_reset_mid_init();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 32'hCAFE_0001;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) reset = 1'b1;
            #3;
            if (i < 7) begin
                checks++;
                if (rf_wa !== 4'(i)) begin
                    errors++;
                    $display("FAIL mid_pre_%0d got wa=%0d", i, rf_wa);
                end
            end
            step();
        end
        for (int j = 0; j < 3; j++) begin
            if (j > 0) step();
            #3;
            checks++;
            if ({busy, gnt0, gnt1, rvalid0, rvalid1, rf_wen, rf_wa, rf_ra,
                 rf_din, rdata0, rdata1} !== 110'h0) begin
                errors++;
                $display("FAIL mid_rst_%0d got %h exp 0", j,
                         {busy, gnt0, gnt1, rvalid0, rvalid1, rf_wen,
                          rf_wa, rf_ra, rf_din, rdata0, rdata1});
            end
        end
        step();
        reset = 1'b0;
        req0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #3;
            checks++;
            if ({busy, rf_wen, rf_wa} !== {2'b11, 4'(i)}) begin
                errors++;
                $display("FAIL mid_init_%0d got busy=%b wen=%b wa=%0d",
                         i, busy, rf_wen, rf_wa);
            end
            step();
        end
        #3;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_done got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_req_during_init();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5;
            end
            #3;
            if (i >= 2) begin
                checks++;
                if (gnt1 !== 1'b0) begin
                    errors++;
                    $display("FAIL init_req_%0d got g1=%b exp 0", i, gnt1);
                end
            end
            step();
        end
        #3;
        checks++;
        if ({busy, gnt1, rf_ra} !== {2'b01, 4'd5}) begin
            errors++;
            $display("FAIL init_req_run got busy=%b g1=%b ra=%0d exp 0 1 5",
                     busy, gnt1, rf_ra);
        end
        step();
        req1 = 1'b0;
        #3;
        checks++;
        if ({rvalid1, rdata1} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL init_req_data got v=%b d=%h exp 1 0", rvalid1, rdata1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        reset = 1'b1; clr = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        test_reset();
        test_init();
        test_write_read();
        test_contention();
        test_clr();
        test_reset_mid_init();
        test_req_during_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_port_arb.md
Name: rf_port_arb

Overview:
- Sequencer and arbiter in front of the 16x32 register file module (rfm).
- After reset it walks all registers and writes INIT_VAL to each.
- It then shares the register file's single read/write access path between two requesters, the core (port 0) and the debug monitor (port 1), using round-robin req/gnt.
- Read data is returned registered, one cycle after the grant.

Parameters:
- AW, 4, register address width; NREGS = 2**AW registers.
- DW, 32, data width.
- INIT_VAL, 0, value written to every register by the init sequence.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  one-cycle pulse; re-runs the init sequence.
- busy  out  1  high while the init sequence runs.
- req0  in  1  core access request; held until gnt0.
- we0  in  1  core write enable (1 = write, 0 = read).
- addr0  in  AW  core register address.
- wdata0  in  DW  core write data.
- gnt0  out  1  core grant, one-cycle pulse.
- rvalid0  out  1  core read data valid, one-cycle pulse.
- rdata0  out  DW  core read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the core signals, for the debug port.
- rf_ra  out  AW  register file read address.
- rf_da  in  DW  register file read data (combinational from rf_ra).
- rf_wen  out  1  register file write enable.
- rf_wa  out  AW  register file write address.
- rf_din  out  DW  register file write data.

Behaviour:
- Reset (asynchronous):
  - State goes to INIT; init counter = 0; last-grant pointer = 1, so the core wins the first tie.
  - All outputs are 0, including busy, gnt*, rvalid*, rdata*, rf_wen, rf_wa, rf_din and rf_ra.
  - Asserting reset mid-operation aborts everything; no write completes after reset assertion.
- INIT state:
  - busy = 1 combinationally while in INIT.
  - Each cycle: rf_wen = 1, rf_wa = counter, rf_din = INIT_VAL; counter increments.
  - After the write to address NREGS-1, the next state is RUN.
  - INIT lasts exactly NREGS cycles (16 by default). busy drops the cycle RUN is entered.
  - No grants are issued in INIT; requests stay pending. clr in INIT is ignored.
- RUN state, each cycle:
  - If clr = 1: the next state is INIT with counter = 0. No grant is issued this cycle, even if requests are present.
  - Otherwise, if exactly one req is high, that port is granted.
  - If both are high, the port not granted last is granted (round-robin), and the pointer updates to the winner.
  - The grant is combinational: gnt_k is high in the same cycle as req_k.
- Granted write (we = 1): rf_wen = 1, rf_wa = addr, rf_din = wdata, in the grant cycle.
- Granted read (we = 0): rf_ra = addr in the grant cycle.
  - The next cycle: rdata_k = rf_da as sampled at the grant edge, and rvalid_k = 1 for one cycle.
  - rdata_k holds its value until the next read on that port.
- rf outputs when there is no grant: rf_wen = 0; rf_ra, rf_wa and rf_din hold 0.
- At most one access per cycle; throughput is one access per cycle total.
- A requester that keeps req high after gnt is treated as issuing a new request.
- Read-after-write: a read granted the cycle after a write to the same address returns the new value, as the register file writes on the clock edge.
- Starvation bound: with both ports requesting continuously, grants alternate 0,1,0,1 and neither port waits more than one cycle.
- Address wrap: the init counter is AW+1 bits so its terminal check is unambiguous. Request addresses are used as-is, with no range check.

Test Plan:
- Init sequence: release reset -> busy = 1 for exactly 16 cycles; rf_wen = 1 with rf_wa = 0..15 and rf_din = 0; busy then goes 0.
- Single-port write/read: core writes 0xDEADBEEF to r5 → gnt0 in the same cycle. Core reads r5 the next cycle → rvalid0 one cycle later, rdata0 = 0xDEADBEEF.
- Contention: req0 and req1 held high for 6 cycles → grants are 0,1,0,1,0,1. Debug reads of r3 return the value written earlier by the core.
- Request during init: req1 asserted at cycle 2 of INIT → no gnt1 until the first RUN cycle, then gnt1 = 1.
- clr vs. request: clr = 1 and req0 = 1 in the same RUN cycle → no gnt0; busy = 1 for 16 cycles; a subsequent read of r5 returns 0.
- Reset mid-init: assert reset at init cycle 7 for 3 cycles → all outputs 0. After release, the init restarts at rf_wa = 0 and takes 16 full cycles.
